// File: rtl/glb_bank_sram_arbiter_if.sv
// Bundle of requester, configuration and SRAM-side signals for the global
// buffer bank SRAM arbiter.
//   slave  : arbiter view (requests/cfg/sram_q in; grants, returns, SRAM drive out)
//   master : environment view (requesters and SRAM macro)
interface glb_bank_sram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  cfg_fixed_prio;
  logic                  p0_req, p1_req;
  logic                  p0_wr, p1_wr;
  logic [ADDR_WIDTH-1:0] p0_addr, p1_addr;
  logic [DATA_WIDTH-1:0] p0_wdata, p1_wdata;
  logic [DATA_WIDTH-1:0] p0_bit_en, p1_bit_en;
  logic                  p0_gnt, p1_gnt;
  logic                  p0_rd_valid, p1_rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  sram_ceb, sram_web;
  logic [DATA_WIDTH-1:0] sram_bweb;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  cfg_fixed_prio,
    input  p0_req, p1_req, p0_wr, p1_wr, p0_addr, p1_addr,
    input  p0_wdata, p1_wdata, p0_bit_en, p1_bit_en,
    output p0_gnt, p1_gnt, p0_rd_valid, p1_rd_valid, rd_data,
    output sram_ceb, sram_web, sram_bweb, sram_a, sram_d,
    input  sram_q
  );

  modport master (
    output cfg_fixed_prio,
    output p0_req, p1_req, p0_wr, p1_wr, p0_addr, p1_addr,
    output p0_wdata, p1_wdata, p0_bit_en, p1_bit_en,
    input  p0_gnt, p1_gnt, p0_rd_valid, p1_rd_valid, rd_data,
    input  sram_ceb, sram_web, sram_bweb, sram_a, sram_d,
    output sram_q
  );
endinterface

// File: rtl/glb_bank_sram_arbiter.sv
// Two-port arbiter and read-return sequencer for one global-buffer bank SRAM.
// Grants at most one request per cycle (round-robin or port-0 fixed priority),
// drives the active-low SRAM controls from the winner, and tracks each read
// through a latency-matched pipeline so data returns to its issuer in order.
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : glb_bank_sram_arbiter_if.slave (requests, grants, returns, SRAM)
module glb_bank_sram_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned RD_LATENCY = 3
) (
  input logic                     clk,
  input logic                     reset_n,
  glb_bank_sram_arbiter_if.slave  bus
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  logic                  gnt0, gnt1, grant_any;
  port_e                 winner, last_gnt;
  logic                  win_wr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata, win_bit_en;

  logic [RD_LATENCY-1:0] trk_vld;
  port_e                 trk_port [RD_LATENCY];

  // On conflict, last_gnt==PORT1 means port 0 is next in round-robin order.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (bus.p0_req && bus.p1_req) begin
      if (bus.cfg_fixed_prio || last_gnt == PORT1) gnt0 = 1'b1;
      else                                         gnt1 = 1'b1;
    end else begin
      gnt0 = bus.p0_req;
      gnt1 = bus.p1_req;
    end
  end

  assign grant_any = gnt0 | gnt1;
  assign winner    = gnt1 ? PORT1 : PORT0;

  // Winner mux; all fields stay zero when idle so sram_a/sram_d read 0.
  always_comb begin
    win_wr     = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    win_bit_en = '0;
    if (gnt1) begin
      win_wr     = bus.p1_wr;
      win_addr   = bus.p1_addr;
      win_wdata  = bus.p1_wdata;
      win_bit_en = bus.p1_bit_en;
    end else if (gnt0) begin
      win_wr     = bus.p0_wr;
      win_addr   = bus.p0_addr;
      win_wdata  = bus.p0_wdata;
      win_bit_en = bus.p0_bit_en;
    end
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.sram_ceb  = ~grant_any;
  assign bus.sram_web  = ~(grant_any & win_wr);
  assign bus.sram_bweb = (grant_any & win_wr) ? ~win_bit_en : '1;
  assign bus.sram_a    = win_addr;
  assign bus.sram_d    = win_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= PORT1;
    end else if (grant_any) begin
      last_gnt <= winner;
    end
  end

  // Read tracking: one {valid, port} entry per cycle of SRAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk_vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) trk_port[i] <= PORT0;
    end else begin
      trk_vld[0]  <= grant_any & ~win_wr;
      trk_port[0] <= winner;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        trk_vld[i]  <= trk_vld[i-1];
        trk_port[i] <= trk_port[i-1];
      end
    end
  end

  assign bus.p0_rd_valid = trk_vld[RD_LATENCY-1] && (trk_port[RD_LATENCY-1] == PORT0);
  assign bus.p1_rd_valid = trk_vld[RD_LATENCY-1] && (trk_port[RD_LATENCY-1] == PORT1);
  assign bus.rd_data     = bus.sram_q;

endmodule

// File: tb/tb_glb_bank_sram_arbiter.sv
// Self-checking bench for glb_bank_sram_arbiter: directed scenarios plus
// randomized traffic, checked every cycle against a behavioural model
// (arbitration rule, reference memory, return schedule keyed by cycle).
module tb_glb_bank_sram_arbiter;
  localparam int LAT = 3;
  localparam int DW  = 64;
  localparam int AW  = 14;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  glb_bank_sram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  glb_bank_sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // SRAM macro model: active-low controls, fixed read latency LAT.
  logic [DW-1:0] mem [0:16383];
  logic [DW-1:0] q_pipe [0:LAT-1];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) q_pipe[i] <= q_pipe[i-1];
    q_pipe[0] <= '0;
    if (!bus.sram_ceb) begin
      if (!bus.sram_web) mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_bweb) | (bus.sram_d & ~bus.sram_bweb);
      else               q_pipe[0] <= mem[bus.sram_a];
    end
  end
  assign bus.sram_q = q_pipe[LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference model.
  logic [DW-1:0] ref_mem [0:16383];
  logic          s_vld  [0:7];
  logic          s_port [0:7];
  logic [DW-1:0] s_data [0:7];
  logic          m_last;
  logic          eg0, eg1, e_any, e_wr, ev0, ev1;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_d, e_be;
  int            slot;

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) s_vld[i] = 1'b0;
      m_last = 1'b1;
      check_eq("rst_p0_rdv", 64'(bus.p0_rd_valid), 64'(0));
      check_eq("rst_p1_rdv", 64'(bus.p1_rd_valid), 64'(0));
      check_eq("rst_ceb",    64'(bus.sram_ceb), 64'(1));
      check_eq("rst_web",    64'(bus.sram_web), 64'(1));
      check_eq("rst_bweb",   bus.sram_bweb, {DW{1'b1}});
      check_eq("rst_a",      64'(bus.sram_a), 64'(0));
      check_eq("rst_d",      bus.sram_d, 64'(0));
    end else begin
      if (bus.p0_req && bus.p1_req) begin
        eg0 = bus.cfg_fixed_prio || m_last;
        eg1 = !eg0;
      end else begin
        eg0 = bus.p0_req;
        eg1 = bus.p1_req;
      end
      e_any = eg0 | eg1;
      e_wr  = eg1 ? bus.p1_wr     : bus.p0_wr;
      e_a   = eg1 ? bus.p1_addr   : bus.p0_addr;
      e_d   = eg1 ? bus.p1_wdata  : bus.p0_wdata;
      e_be  = eg1 ? bus.p1_bit_en : bus.p0_bit_en;
      check_eq("p0_gnt",   64'(bus.p0_gnt), 64'(eg0));
      check_eq("p1_gnt",   64'(bus.p1_gnt), 64'(eg1));
      check_eq("sram_ceb", 64'(bus.sram_ceb), 64'(!e_any));
      check_eq("sram_web", 64'(bus.sram_web), 64'(!(e_any && e_wr)));
      check_eq("sram_bweb", bus.sram_bweb, (e_any && e_wr) ? ~e_be : {DW{1'b1}});
      check_eq("sram_a",   64'(bus.sram_a), e_any ? 64'(e_a) : 64'(0));
      check_eq("sram_d",   bus.sram_d, e_any ? e_d : 64'(0));
      slot = cyc % 8;
      ev0 = s_vld[slot] && !s_port[slot];
      ev1 = s_vld[slot] &&  s_port[slot];
      check_eq("p0_rd_valid", 64'(bus.p0_rd_valid), 64'(ev0));
      check_eq("p1_rd_valid", 64'(bus.p1_rd_valid), 64'(ev1));
      if (s_vld[slot]) check_eq("rd_data", bus.rd_data, s_data[slot]);
      s_vld[slot] = 1'b0;
      if (e_any) begin
        m_last = eg1;
        if (e_wr) begin
          ref_mem[e_a] = (ref_mem[e_a] & ~e_be) | (e_d & e_be);
        end else begin
          s_vld[(cyc + LAT) % 8]  = 1'b1;
          s_port[(cyc + LAT) % 8] = eg1;
          s_data[(cyc + LAT) % 8] = ref_mem[e_a];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.p0_req = 1'b0; bus.p0_wr = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_bit_en = '0;
    bus.p1_req = 1'b0; bus.p1_wr = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_bit_en = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic g0, g1;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < LAT; i++) q_pipe[i] = '0;
    for (int i = 0; i < 8; i++) s_vld[i] = 1'b0;
    m_last = 1'b1;
    mem[16'h0010]     = 64'hDEADBEEF_00000001;
    ref_mem[16'h0010] = 64'hDEADBEEF_00000001;
    bus.cfg_fixed_prio = 1'b0;
    clear_reqs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Round-robin conflict from reset: p0 first, then alternate.
    tick();
    bus.p0_req = 1'b1; bus.p0_addr = 14'h0010;
    bus.p1_req = 1'b1; bus.p1_addr = 14'h0011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("rr_p0_gnt", 64'(bus.p0_gnt), 64'(k % 2 == 0));
      check_eq("rr_p1_gnt", 64'(bus.p1_gnt), 64'(k % 2 == 1));
      tick();
    end
    clear_reqs();
    repeat (4) tick();

    // Single read of preloaded word.
    bus.p0_req = 1'b1; bus.p0_addr = 14'h0010;
    @(negedge clk);
    check_eq("sr_gnt", 64'(bus.p0_gnt), 64'(1));
    tick();
    clear_reqs();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("sr_p0_rdv", 64'(bus.p0_rd_valid), 64'(k == LAT));
      check_eq("sr_p1_rdv", 64'(bus.p1_rd_valid), 64'(0));
      if (k == LAT) check_eq("sr_data", bus.rd_data, 64'hDEADBEEF_00000001);
    end

    // Fixed priority: p0 wins while it requests; p1 follows when p0 drops.
    tick();
    bus.cfg_fixed_prio = 1'b1;
    bus.p0_req = 1'b1; bus.p0_addr = 14'h0001;
    bus.p1_req = 1'b1; bus.p1_addr = 14'h0002;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("fp_p0_gnt", 64'(bus.p0_gnt), 64'(1));
      check_eq("fp_p1_gnt", 64'(bus.p1_gnt), 64'(0));
      tick();
    end
    bus.p0_req = 1'b0;
    @(negedge clk);
    check_eq("fp_p1_after", 64'(bus.p1_gnt), 64'(1));
    tick();
    clear_reqs();
    bus.cfg_fixed_prio = 1'b0;
    repeat (4) tick();

    // Masked write then read of the same address.
    bus.p1_req = 1'b1; bus.p1_wr = 1'b1; bus.p1_addr = 14'h3FFF;
    bus.p1_wdata = 64'hFFFF_FFFF_FFFF_FFFF; bus.p1_bit_en = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);
    check_eq("mw_bweb", bus.sram_bweb, 64'hFFFF_FFFF_0000_0000);
    check_eq("mw_web",  64'(bus.sram_web), 64'(0));
    tick();
    bus.p1_wr = 1'b0;
    @(negedge clk);
    check_eq("mw_rd_gnt", 64'(bus.p1_gnt), 64'(1));
    tick();
    clear_reqs();
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check_eq("mw_p1_rdv", 64'(bus.p1_rd_valid), 64'(k == LAT));
      if (k == LAT) check_eq("mw_data", bus.rd_data, 64'h0000_0000_FFFF_FFFF);
    end

    // Reset while a read is in flight: its return is dropped.
    tick();
    bus.p0_req = 1'b1; bus.p0_addr = 14'h0010;
    @(negedge clk);
    check_eq("rm_gnt", 64'(bus.p0_gnt), 64'(1));
    tick();
    clear_reqs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rm_no_rdv", 64'(bus.p0_rd_valid), 64'(0));
    tick();
    bus.p0_req = 1'b1; bus.p1_req = 1'b1;
    @(negedge clk);
    check_eq("rm_conf_p0", 64'(bus.p0_gnt), 64'(1));
    check_eq("rm_conf_p1", 64'(bus.p1_gnt), 64'(0));
    tick();
    clear_reqs();
    repeat (4) tick();

    // Idle window.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("idle_ceb", 64'(bus.sram_ceb), 64'(1));
      check_eq("idle_web", 64'(bus.sram_web), 64'(1));
      check_eq("idle_rdv", 64'({bus.p0_rd_valid, bus.p1_rd_valid}), 64'(0));
    end

    // Random traffic: requests held until granted, small address window for RAW.
    g0 = 1'b1; g1 = 1'b1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if ($urandom_range(0, 19) == 0) bus.cfg_fixed_prio = ~bus.cfg_fixed_prio;
      if (!bus.p0_req || g0) begin
        bus.p0_req = ($urandom_range(0, 99) < 60);
        bus.p0_wr = $urandom_range(0, 2) == 0;
        bus.p0_addr = 14'($urandom_range(0, 15));
        bus.p0_wdata = {$urandom, $urandom};
        bus.p0_bit_en = {$urandom, $urandom};
      end
      if (!bus.p1_req || g1) begin
        bus.p1_req = ($urandom_range(0, 99) < 60);
        bus.p1_wr = $urandom_range(0, 2) == 0;
        bus.p1_addr = 14'($urandom_range(0, 15));
        bus.p1_wdata = {$urandom, $urandom};
        bus.p1_bit_en = {$urandom, $urandom};
      end
      @(negedge clk);
      g0 = bus.p0_gnt;
      g1 = bus.p1_gnt;
    end
    tick();
    clear_reqs();
    repeat (LAT + 3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/glb_bank_sram_arbiter.md
# glb_bank_sram_arbiter

Two-port arbiter and read-return sequencer for one global-buffer bank SRAM (`glb_bank_sram_gen`, active-low single-port interface, fixed read latency). It shares the single SRAM port between a processor-side requester (port 0) and a fabric/stream-side requester (port 1). Each cycle it grants at most one request and drives the SRAM controls. It tracks every issued read through a latency-matched pipeline, so read data returns to the requester that issued it, in order.

## Interface
Parameters:
- `DATA_WIDTH`, 64: SRAM word width.
- `ADDR_WIDTH`, 14: SRAM word address width.
- `RD_LATENCY`, 3: cycles from SRAM request to valid `sram_q` (2 input pipeline stages + macro). Must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all state on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `cfg_fixed_prio`  in  1: 0 = round-robin, 1 = port 0 always wins. Quasi-static.
- `p0_req`, `p1_req`  in  1: request valid.
- `p0_wr`, `p1_wr`  in  1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  ADDR_WIDTH: word address.
- `p0_wdata`, `p1_wdata`  in  DATA_WIDTH: write data.
- `p0_bit_en`, `p1_bit_en`  in  DATA_WIDTH: active-high bit write enable. Ignored on reads.
- `p0_gnt`, `p1_gnt`  out  1: request accepted this cycle (combinational).
- `p0_rd_valid`, `p1_rd_valid`  out  1: read data valid for this port.
- `rd_data`  out  DATA_WIDTH: read data, shared by both ports.
- `sram_ceb`, `sram_web`  out  1: active-low chip/write enable.
- `sram_bweb`  out  DATA_WIDTH: active-low bit write enable.
- `sram_a`  out  ADDR_WIDTH: address.
- `sram_d`  out  DATA_WIDTH: write data.
- `sram_q`  in  DATA_WIDTH: SRAM read data.

## Operation
- Request/grant: a request is held until the same cycle `pX_gnt`=1, then it is consumed. No backpressure on read returns.
- Arbitration:
  - Only one port requesting → that port is granted.
  - Both requesting, `cfg_fixed_prio`=1 → port 0 is granted.
  - Both requesting, `cfg_fixed_prio`=0 → the port opposite `last_gnt` is granted.
- `last_gnt` register: updates to the granted port on every grant, in both modes. Reset value 1, so port 0 wins the first conflict.
- SRAM drive, combinational from the winner:
  - `sram_ceb` = ~grant_any.
  - `sram_web` = ~(grant_any & wr).
  - `sram_bweb` = ~bit_en on writes, all-ones otherwise.
  - `sram_a` and `sram_d` come from the winner. They are 0 when idle.
- Read tracking: shift register of RD_LATENCY entries, each {valid, port}.
  - Stage 0 loads {grant_any & ~wr, winner}.
  - The last stage drives `pX_rd_valid` = valid & (port==X).
  - `rd_data` = `sram_q`, passed through unregistered.
- Writes create no return.
- Read-after-write to the same address on consecutive cycles returns the new data. The SRAM serialises these, so the arbiter adds no hazard logic.

## Timing
- Grant: zero cycles after request (same cycle).
- Read issued in cycle t → `pX_rd_valid`=1 in cycle t+RD_LATENCY, exactly one cycle.
- Back-to-back reads: one return per cycle, in issue order, interleaved by port as granted.
- Throughput: one access per cycle, total across both ports.
- While `reset_n`=0, asynchronously:
  - all tracking entries are invalid.
  - `last_gnt`=1.
  - `p0/p1_rd_valid`=0.
- With no requests asserted during reset, SRAM outputs are idle: `sram_ceb`=1, `sram_web`=1, `sram_bweb` all-ones, `sram_a`=0, `sram_d`=0.
- Grants are combinational and are not gated by reset. Requesters hold `pX_req`=0 during reset.
- Reset mid-operation: in-flight reads are dropped. No `rd_valid` is produced for them after reset releases.
- Simultaneous grant and return in the same cycle are independent; both proceed.
- `cfg_fixed_prio` change: takes effect on the next arbitration. `last_gnt` is preserved across the change.

## Test plan
- Single read: p0 reads addr 0x0010, preloaded with 0xDEADBEEF_00000001, at cycle 5 → `p0_gnt`=1 in cycle 5; `p0_rd_valid`=1 in cycle 8 only, with `rd_data`=0xDEADBEEF_00000001; `p1_rd_valid` stays 0.
- Round-robin conflict: both ports request reads every cycle for 6 cycles, `cfg_fixed_prio`=0 → grants alternate p0,p1,p0,p1,p0,p1. Returns alternate identically, each 3 cycles after its grant.
- Fixed priority: both request for 4 cycles, `cfg_fixed_prio`=1 → p0 granted all 4 cycles, `p1_gnt`=0. When p0 drops, p1 is granted the next cycle.
- Masked write then read: p1 writes 0xFFFF_FFFF_FFFF_FFFF to addr 0x3FFF with `bit_en`=0x0000_0000_FFFF_FFFF over an old value of 0 → `sram_bweb`=0xFFFF_FFFF_0000_0000 and `sram_web`=0 that cycle. A p1 read of addr 0x3FFF on the next cycle returns 0x0000_0000_FFFF_FFFF after 3 cycles.
- Reset mid-flight: p0 read granted in cycle 10; `reset_n` low in cycle 11, released in cycle 12 → no `p0_rd_valid` in cycle 13. After reset, the first conflict grants p0.
- Idle: no requests for 20 cycles → `sram_ceb`=1, `sram_web`=1, and both `rd_valid` stay 0 throughout.
